uart_tx_fifo: RTL and testbench

Byte FIFO and issue sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the core at full clock rate, buffers them, and hands them one at a time to the transmitter through its `sdata` / `tx_start` / `tx_busy` handshake. Software can write a burst of bytes without polling the transmitter between bytes.

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus issue sequencer feeding a UART transmitter. Bytes are
//   accepted at full clock rate and handed to the transmitter one at a time
//   through the sdata / tx_start / tx_busy handshake.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   ADDR_W       pointer width, $clog2(DEPTH)
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   wr_en        write strobe; wr_data pushed when wr_en && !full
//   wr_data      byte to enqueue
//   full         count == DEPTH
//   empty        count == 0
//   count        occupancy, 0..DEPTH
//   overflow     sticky, set on wr_en && full; cleared by reset/clr_overflow
//   clr_overflow clears overflow (a same-cycle overflow event wins)
//   idle         FIFO empty and sequencer idle
//   sdata        byte to transmitter, stable from tx_start to next tx_start
//   tx_start     one-cycle start pulse to transmitter
//   tx_busy      transmitter busy, rises one cycle after it samples tx_start
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              idle,
  output logic [7:0]        sdata,
  output logic              tx_start,
  input  logic              tx_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_DRAIN
  } state_t;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              overflow_q, overflow_d;
  state_t            state_q,  state_d;
  logic [7:0]        sdata_q,  sdata_d;
  logic              tx_start_q, tx_start_d;

  logic              push;
  logic              pop;
  logic              full_w;
  logic              empty_w;

  // Status derives only from registered count, so wr_en has no
  // combinational path to full/empty/idle.
  assign full_w  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_w = (count_q == '0);

  // Full is judged on the current count: a same-cycle pop never makes room.
  assign push = wr_en && !full_w;

  // Sequencer: the only pop point is the IDLE->START transition.
  always_comb begin
    state_d    = state_q;
    sdata_d    = sdata_q;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_w) begin
          pop        = 1'b1;
          sdata_d    = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        state_d = S_ARM;
      end
      // Covers the transmitter's one-cycle tx_busy latency; busy is not
      // looked at until DRAIN.
      S_ARM: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Set has priority over clear.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && full_w) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      sdata_q    <= '0;
      tx_start_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      sdata_q    <= sdata_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign idle     = empty_w && (state_q == S_IDLE);
  assign sdata    = sdata_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: randomized traffic checked every cycle
// against a queue-based timing model of the FIFO and issue sequencer.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          clr_overflow = 1'b0;
  logic          full, empty, overflow, idle, tx_start;
  logic [AW:0]   count;
  logic [7:0]    sdata;
  logic          tx_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .idle         (idle),
    .sdata        (sdata),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy)
  );

  // Transmitter model: busy for busy_len cycles starting one cycle after it
  // samples tx_start. Not reset: a byte already handed off completes.
  int   busy_len = 4;
  int   busy_cnt = 0;
  logic busy_r = 1'b0;
  logic hold_busy = 1'b0;
  int   starts_seen = 0;
  assign tx_busy = busy_r | hold_busy;

  always @(posedge clk) begin
    if (tx_start) begin
      busy_r   <= 1'b1;
      busy_cnt <= busy_len;
      starts_seen <= starts_seen + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) busy_r <= 1'b0;
    end
  end

  // Reference model: byte queue, sticky overflow, and the single
  // outstanding byte with the edge it was started on.
  logic [7:0] mq[$];
  bit         m_out = 1'b0;
  int         m_start = 0;
  bit         m_ov = 1'b0;
  logic [7:0] m_sdata = '0;
  int         k = 0;
  bit         m_started = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("count",    32'(count),    32'(mq.size()));
    check("full",     32'(full),     32'(mq.size() == DEPTH));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("tx_start", 32'(tx_start), 32'(m_started));
    check("sdata",    32'(sdata),    32'(m_sdata));
    check("idle",     32'(idle),     32'(mq.size() == 0 && !m_out));
  endtask

  // Called #1 after a rising edge; drives inputs for the next edge,
  // advances the model across that edge and checks #1 after it.
  task automatic step(input logic w, input logic [7:0] d, input logic c);
    logic b;
    bit   rdy;
    bit   full_pre;
    wr_en = w;
    wr_data = d;
    clr_overflow = c;
    #3;
    b = tx_busy;
    @(posedge clk);
    k++;
    full_pre  = (mq.size() == DEPTH);
    rdy       = !m_out;
    m_started = 1'b0;
    // DRAIN first sees busy three edges after the start edge.
    if (m_out && k >= m_start + 3 && !b) m_out = 1'b0;
    if (rdy && mq.size() > 0) begin
      m_sdata   = mq.pop_front();
      m_out     = 1'b1;
      m_start   = k;
      m_started = 1'b1;
    end
    if (w && !full_pre) mq.push_back(d);
    if (w && full_pre) m_ov = 1'b1;
    else if (c) m_ov = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = 1'b0;
    m_ov = 1'b0;
    m_sdata = '0;
    m_started = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    wr_en = 1'b0;
    clr_overflow = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_count",    32'(count),    32'd0);
    check("rst_full",     32'(full),     32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_idle",     32'(idle),     32'd1);
    check("rst_sdata",    32'(sdata),    32'h00);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    model_reset();
    @(posedge clk);
    k++;
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((mq.size() != 0 || m_out) && n < bound) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n >= bound) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int s0;
    int written;
    int guard;

    // Power-up reset, then 20 quiet cycles.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_outputs();
    repeat (20) step(1'b0, 8'h00, 1'b0);

    // Single byte with a long frame.
    busy_len = 100;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("single_sdata", 32'(sdata), 32'hA5);
    drain(300);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // Burst of 16 consecutive writes, ordering checked by the model.
    busy_len = 20;
    s0 = starts_seen;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    check("burst_no_ovf", 32'(overflow), 32'd0);
    drain(3000);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    check("burst_starts", 32'(starts_seen - s0), 32'd16);

    // Overflow with the sequencer stalled.
    hold_busy = 1'b1;
    guard = 0;
    while (mq.size() < DEPTH && guard < 40) begin
      step(1'b1, 8'($urandom), 1'b0);
      guard++;
    end
    check("ovf_filled", 32'(full), 32'd1);
    step(1'b1, 8'hFF, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'(DEPTH));
    step(1'b1, 8'hEE, 1'b1);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);
    hold_busy = 1'b0;
    drain(3000);

    // Wrap-around: 40 random bytes, occupancy kept at or below 3.
    written = 0;
    guard = 0;
    while ((written < 40 || mq.size() != 0 || m_out) && guard < 3000) begin
      busy_len = int'($urandom_range(1, 6));
      if (written < 40 && mq.size() < 3 && ($urandom % 2) == 0) begin
        step(1'b1, 8'($urandom), 1'b0);
        written++;
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
      guard++;
    end
    if (guard >= 3000) check("wrap_timeout", 32'd1, 32'd0);

    // Reset during DRAIN with 5 bytes queued.
    busy_len = 30;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    guard = 0;
    while (!(m_out && k >= m_start + 4) && guard < 50) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    async_reset();
    s0 = starts_seen;
    repeat (20) step(1'b0, 8'h00, 1'b0);
    check("no_start_after_rst", 32'(starts_seen - s0), 32'd0);
    step(1'b1, 8'h3C, 1'b0);
    drain(300);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
